// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter between the MEM-stage core port and a matrix unit.
// Matrix line bursts run uninterrupted; the core is stalled while a burst owns the port.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_func3,
  output logic        cpu_stall,
  input  logic        mx_req,
  input  logic        mx_wr,
  input  logic [31:0] mx_base,
  input  logic [3:0]  mx_len,
  input  logic [31:0] mx_wdata,
  output logic        mx_wready,
  output logic        mx_rvalid,
  output logic [31:0] mx_rdata,
  output logic        mx_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_byte_sel,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned SLW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned SW   = (SLW < 3) ? 3 : SLW;
  localparam int unsigned LENW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MX_RUN  = 2'd1,
    MX_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LENW-1:0]   beat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic [31:0]       lat_base;
  logic [LENW-1:0]   lat_len;
  logic              lat_wr;

  logic              core_acc;
  logic              starve_hit;
  logic              grant;
  logic              last_beat;

  // funct3[2] (load sign extension) is the core's concern, not the memory's
  logic              unused_func3;
  assign unused_func3 = cpu_func3[2];

  assign core_acc   = cpu_rd | cpu_wr;
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant      = (state == IDLE) && mx_req && (!core_acc || starve_hit);
  assign last_beat  = (state == MX_RUN) && (beat_cnt == lat_len);

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = MX_RUN;
      MX_RUN:  if (last_beat) state_nxt = MX_DONE;
      MX_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, burst bookkeeping and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      lat_base   <= '0;
      lat_len    <= '0;
      lat_wr     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            lat_base   <= mx_base;
            lat_len    <= mx_len;
            lat_wr     <= mx_wr;
            beat_cnt   <= '0;
            starve_cnt <= '0;
          end else if (!mx_req) begin
            starve_cnt <= '0;
          end else if (starve_cnt != {SW{1'b1}}) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        MX_RUN:  beat_cnt <= beat_cnt + LENW'(1);
        default: ;
      endcase
    end
  end

  // Port steering: core passes through except while a burst owns the memory.
  // mem_re/mem_we are gated by rst so reset blocks any access immediately.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_re       = cpu_rd & rst;
    mem_we       = cpu_wr & rst;
    mem_byte_sel = cpu_func3[1:0];
    cpu_stall    = 1'b0;
    mx_wready    = 1'b0;
    mx_rvalid    = 1'b0;
    mx_rdata     = '0;
    mx_done      = 1'b0;
    case (state)
      MX_RUN: begin
        mem_addr     = lat_base + 32'({beat_cnt, 2'b00});
        mem_wdata    = mx_wdata;
        mem_re       = !lat_wr;
        mem_we       = lat_wr;
        mem_byte_sel = 2'b10;
        cpu_stall    = core_acc;
        mx_wready    = lat_wr;
        mx_rvalid    = !lat_wr;
        mx_rdata     = mem_rdata;
      end
      MX_DONE: mx_done = 1'b1;
      default: ;
    endcase
  end

endmodule
